// File: rtl/neural_pkg.sv
// Shared entry-layout constants and lifetime helpers for the lifetime FIFO family.
// An entry is {value, lifetime}, and the lifetime field occupies the low bits.
package neural_pkg;

    localparam int VAL_W_DEF = 16;
    localparam int LT_W_DEF  = 16;
    localparam int LT_LSB    = 0;

    typedef enum logic [1:0] {
        POP_NONE,
        POP_RECIRC,
        POP_DISCARD
    } pop_kind_e;

    function automatic int lt_msb(input int lt_w);
        return LT_LSB + lt_w - 1;
    endfunction

    function automatic int val_lsb(input int lt_w);
        return LT_LSB + lt_w;
    endfunction

    function automatic int val_msb(input int val_w, input int lt_w);
        return val_lsb(lt_w) + val_w - 1;
    endfunction

    // A stored lifetime of 0 behaves like 1: this visit is the last one.
    function automatic logic lt_recirc(input logic [31:0] lt);
        return lt > 32'd1;
    endfunction

    function automatic logic [31:0] lt_dec(input logic [31:0] lt);
        return (lt > 32'd1) ? lt - 32'd1 : 32'd0;
    endfunction

endpackage

// File: rtl/lt_fifo_mem.sv
// Lifetime FIFO storage: DEPTH entries, with two write ports and one asynchronous read port.
// The two write addresses are always distinct, so no write-collision arbitration is needed.
module lt_fifo_mem #(
    parameter int W     = 32,
    parameter int DEPTH = 1024
) (
    input  logic                       clk,
    input  logic                       we0,
    input  logic [$clog2(DEPTH)-1:0]   addr0,
    input  logic [W-1:0]               wdata0,
    input  logic                       we1,
    input  logic [$clog2(DEPTH)-1:0]   addr1,
    input  logic [W-1:0]               wdata1,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [W-1:0]               rdata
);

    logic [W-1:0] mem [DEPTH];

    // NOTE: storage has no reset; the pointers alone decide which slots are valid.
    always_ff @(posedge clk) begin
        if (we0) mem[addr0] <= wdata0;
        if (we1) mem[addr1] <= wdata1;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lifetime_fifo.sv
// Lifetime FIFO: a popped head with lifetime > 1 is re-queued at the tail, with its lifetime decremented.
// Defining LT_FIFO_STATS_EN adds the pop_total and high_water statistics outputs.
module lifetime_fifo
    import neural_pkg::*;
#(
    parameter int VAL_W = VAL_W_DEF,
    parameter int LT_W  = LT_W_DEF,
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [VAL_W+LT_W-1:0]    data_in,
    input  logic                     pop,
    input  logic                     flush,
    output logic [VAL_W+LT_W-1:0]    data_out,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
`ifdef LT_FIFO_STATS_EN
    ,
    output logic [31:0]              pop_total,
    output logic [$clog2(DEPTH):0]   high_water
`endif
);

    localparam int EW     = VAL_W + LT_W;
    localparam int AW     = $clog2(DEPTH);
    localparam int CW     = AW + 1;
    localparam int LT_HI  = lt_msb(LT_W);
    localparam int VAL_LO = val_lsb(LT_W);
    localparam int VAL_HI = val_msb(VAL_W, LT_W);

    logic [AW-1:0]   head, tail;
    logic [EW-1:0]   head_entry, recirc_entry;
    logic [LT_W-1:0] head_lt, in_lt;
    logic            active, push_ok, push_rej, pop_empty;
    pop_kind_e       pop_kind;
    logic            we0, we1;
    logic [AW-1:0]   waddr0, waddr1;
    logic [EW-1:0]   wdata0, wdata1;
    logic [1:0]      n_wr;
    logic [CW-1:0]   count_nx;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign head_lt  = head_entry[LT_HI:LT_LSB];
    assign in_lt    = data_in[LT_HI:LT_LSB];
    assign data_out = empty ? '0 : head_entry;
    assign active   = !reset && !flush;

    // NOTE: every signal gets a default first, so this block cannot infer a latch.
    always_comb begin
        push_ok   = active && push && (in_lt != '0) && !full;
        push_rej  = active && push && (in_lt != '0) && full;
        pop_empty = active && pop && empty;
        pop_kind  = POP_NONE;
        if (active && pop && !empty)
            pop_kind = lt_recirc(32'(head_lt)) ? POP_RECIRC : POP_DISCARD;

        recirc_entry = {head_entry[VAL_HI:VAL_LO], LT_W'(lt_dec(32'(head_lt)))};
        waddr0 = tail;
        waddr1 = tail + AW'(1);
        wdata0 = data_in;
        wdata1 = data_in;
        we0    = push_ok;
        we1    = 1'b0;
        // The recirculated head lands ahead of any push made in the same cycle.
        if (pop_kind == POP_RECIRC) begin
            we0    = 1'b1;
            wdata0 = recirc_entry;
            we1    = push_ok;
        end

        n_wr     = {1'b0, we0} + {1'b0, we1};
        count_nx = count + CW'(push_ok) - CW'(pop_kind == POP_DISCARD);
    end

    // NOTE: non-blocking assignments, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (pop_kind != POP_NONE) head <= head + AW'(1);
            tail  <= tail + AW'(n_wr);
            count <= count_nx;
            if (push_rej)  overflow  <= 1'b1;
            if (pop_empty) underflow <= 1'b1;
        end
    end

`ifdef LT_FIFO_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            pop_total  <= '0;
            high_water <= '0;
        end else if (!flush) begin
            if (pop_kind != POP_NONE) pop_total <= pop_total + 32'd1;
            if (count_nx > high_water) high_water <= count_nx;
        end
    end
`endif

    lt_fifo_mem #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk    (clk),
        .we0    (we0),
        .addr0  (waddr0),
        .wdata0 (wdata0),
        .we1    (we1),
        .addr1  (waddr1),
        .wdata1 (wdata1),
        .raddr  (head),
        .rdata  (head_entry)
    );

endmodule
